add_sub_result_fifo: RTL

Buffers results of the add/sub stage (`_C` result, `_O` overflow) in a small synchronous FIFO with valid/ready handshakes on both sides. It sits directly downstream of the add/sub unit and decouples its combinational output from a slower consumer, such as the register write-back or a test harness. It also keeps a sticky overflow flag and a saturating overflow event counter.

---
 rtl/add_sub_result_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/add_sub_result_fifo.sv
// Result FIFO behind the add/sub stage: buffers {_O, _C} with valid/ready on both sides and
// tracks overflow (sticky flag + saturating counter). Optional macro: ADD_SUB_RESULT_FIFO_SATURATE_EN.
module add_sub_result_fifo #(
    parameter int data_width = 16,
    parameter int depth      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [data_width-1:0]     _C,
    input  logic                      _O,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [data_width-1:0]     out_data,
    output logic                      out_ovf,
    output logic [$clog2(depth):0]    count,
    output logic                      ovf_sticky,
    output logic [7:0]                ovf_events,
    input  logic                      clr_ovf
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [data_width:0]   r_mem [depth];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf_sticky;
    logic [7:0]            r_ovf_events;

    logic                  w_push;
    logic                  w_pop;
    logic [data_width-1:0] w_store_data;

    // in_ready comes from registered count only, so a full FIFO refuses a push even when popping.
    assign in_ready  = (r_count != CW'(depth));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

`ifdef ADD_SUB_RESULT_FIFO_SATURATE_EN
    // On overflow the sign bit of _C is inverted relative to the true result.
    always_comb begin
        w_store_data = _C;
        if (_O) begin
            w_store_data = _C[data_width-1] ? {1'b0, {(data_width-1){1'b1}}}
                                            : {1'b1, {(data_width-1){1'b0}}};
        end
    end
`else
    assign w_store_data = _C;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {_O, w_store_data};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A simultaneous overflow push beats clr_ovf: the count restarts at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_events <= '0;
        end else if (w_push && _O) begin
            r_ovf_sticky <= 1'b1;
            if (clr_ovf) begin
                r_ovf_events <= 8'd1;
            end else if (r_ovf_events != 8'hFF) begin
                r_ovf_events <= r_ovf_events + 8'd1;
            end
        end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_events <= '0;
        end
    end

    assign out_data   = r_mem[r_rd_ptr][data_width-1:0];
    assign out_ovf    = r_mem[r_rd_ptr][data_width];
    assign count      = r_count;
    assign ovf_sticky = r_ovf_sticky;
    assign ovf_events = r_ovf_events;

endmodule
